// File: rtl/uart_dmi_framer.sv
// ---------------------------------------------------------------------------
// uart_dmi_framer
//
// Host command framer sitting on the host-facing side of the UART block.
// Pops bytes from the UART RX FIFO and assembles READ/WRITE frames. Each
// complete frame produces exactly one DMI request. The DMI response is then
// serialised back into the UART TX FIFO.
//
// Frame:    byte 0 = command (0x01 READ, 0x02 WRITE)
//           byte 1 = address (low ADDR_WIDTH bits used)
//           bytes 2..5 = write data, LSB first (WRITE only)
// Response: status byte {6'b0, resp_op}; a successful READ is followed by
//           the 4 read-data bytes, LSB first. An unknown command is answered
//           with 0xFF and produces no DMI activity.
//
// Ports
//   CLK_I             system clock
//   RST_I             synchronous active-high reset
//   UART_RE_O         pop strobe to UART RX FIFO (combinational)
//   UART_RX_EMPTY_I   UART RX FIFO empty
//   UART_DREC_I       received byte, valid while UART_RE_O=1
//   UART_WE_O         push strobe to UART TX FIFO (combinational)
//   UART_TX_READY_I   UART TX FIFO not full
//   UART_DSEND_O      byte to transmit, valid while UART_WE_O=1
//   DMI_REQ_VALID_O   DMI request valid
//   DMI_REQ_READY_I   DMI request accepted
//   DMI_REQ_OP_O      1 = read, 2 = write
//   DMI_REQ_ADDR_O    DMI request address
//   DMI_REQ_DATA_O    DMI write data
//   DMI_RESP_VALID_I  DMI response valid
//   DMI_RESP_READY_O  DMI response accepted
//   DMI_RESP_OP_I     response status: 0 ok, 2 failed, 3 busy
//   DMI_RESP_DATA_I   DMI read data
//   BUSY_O            high whenever the FSM is not in IDLE
//
// States
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   IDLE         | waiting for a command byte
//   GET_ADDR     | command latched, waiting for the address byte
//   GET_DATA     | WRITE: collecting 4 data bytes, LSB first
//   DMI_REQ      | request valid, waiting for DMI_REQ_READY_I
//   DMI_RESP     | response ready, waiting for DMI_RESP_VALID_I
//   SEND_STATUS  | pushing the status byte (or 0xFF NAK)
//   SEND_DATA    | READ ok: pushing 4 read-data bytes, LSB first
// ---------------------------------------------------------------------------
module uart_dmi_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ADDR_WIDTH     = 7
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,

    output logic                  UART_RE_O,
    input  logic                  UART_RX_EMPTY_I,
    input  logic [7:0]            UART_DREC_I,

    output logic                  UART_WE_O,
    input  logic                  UART_TX_READY_I,
    output logic [7:0]            UART_DSEND_O,

    output logic                  DMI_REQ_VALID_O,
    input  logic                  DMI_REQ_READY_I,
    output logic [1:0]            DMI_REQ_OP_O,
    output logic [ADDR_WIDTH-1:0] DMI_REQ_ADDR_O,
    output logic [31:0]           DMI_REQ_DATA_O,

    input  logic                  DMI_RESP_VALID_I,
    output logic                  DMI_RESP_READY_O,
    input  logic [1:0]            DMI_RESP_OP_I,
    input  logic [31:0]           DMI_RESP_DATA_I,

    output logic                  BUSY_O
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES);
    // Inter-byte timer is a down-counter: reloaded on every consumed byte and
    // on entry to a receive state, expiring when it reaches zero. That gives
    // exactly TIMEOUT_CYCLES byte-less cycles before the frame is dropped.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] NAK_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET_ADDR    = 3'd1,
        S_GET_DATA    = 3'd2,
        S_DMI_REQ     = 3'd3,
        S_DMI_RESP    = 3'd4,
        S_SEND_STATUS = 3'd5,
        S_SEND_DATA   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            status_q, status_d;
    logic [1:0]            idx_q, idx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  rx_state;
    logic                  tx_pending;
    logic                  rx_pop;
    logic                  tx_push;

    // RX/TX strobes are masked during reset so no FIFO byte is popped or
    // pushed while the framer is discarding its state.
    assign rx_state   = (state_q == S_IDLE) || (state_q == S_GET_ADDR) ||
                        (state_q == S_GET_DATA);
    assign tx_pending = (state_q == S_SEND_STATUS) || (state_q == S_SEND_DATA);
    assign rx_pop     = rx_state & ~UART_RX_EMPTY_I & ~RST_I;
    assign tx_push    = tx_pending & UART_TX_READY_I & ~RST_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            status_q <= 8'd0;
            idx_q    <= 2'd0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (rx_pop) begin
                    if (UART_DREC_I == CMD_READ || UART_DREC_I == CMD_WRITE) begin
                        op_d    = UART_DREC_I[1:0];
                        wdata_d = 32'd0;
                        tmo_d   = TMO_LOAD;
                        state_d = S_GET_ADDR;
                    end else begin
                        status_d = NAK_BYTE;
                        state_d  = S_SEND_STATUS;
                    end
                end
            end

            S_GET_ADDR: begin
                if (rx_pop) begin
                    addr_d = UART_DREC_I[ADDR_WIDTH-1:0];
                    tmo_d  = TMO_LOAD;
                    if (op_q == OP_READ) begin
                        state_d = S_DMI_REQ;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = S_GET_DATA;
                    end
                end else if (tmo_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end

            S_GET_DATA: begin
                if (rx_pop) begin
                    wdata_d[8*idx_q +: 8] = UART_DREC_I;
                    idx_d = idx_q + 2'd1;
                    tmo_d = TMO_LOAD;
                    if (idx_q == 2'd3) begin
                        state_d = S_DMI_REQ;
                    end
                end else if (tmo_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end

            S_DMI_REQ: begin
                if (DMI_REQ_READY_I) begin
                    state_d = S_DMI_RESP;
                end
            end

            S_DMI_RESP: begin
                if (DMI_RESP_VALID_I) begin
                    rdata_d  = DMI_RESP_DATA_I;
                    status_d = {6'b0, DMI_RESP_OP_I};
                    state_d  = S_SEND_STATUS;
                end
            end

            S_SEND_STATUS: begin
                if (tx_push) begin
                    // A NAK (0xFF) is never zero, so a stale READ op from an
                    // earlier frame cannot send it into SEND_DATA.
                    if (op_q == OP_READ && status_q == 8'h00) begin
                        idx_d   = 2'd0;
                        state_d = S_SEND_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_SEND_DATA: begin
                if (tx_push) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        UART_DSEND_O = 8'h00;
        if (state_q == S_SEND_STATUS) begin
            UART_DSEND_O = status_q;
        end else if (state_q == S_SEND_DATA) begin
            UART_DSEND_O = rdata_q[8*idx_q +: 8];
        end
    end

    assign UART_RE_O        = rx_pop;
    assign UART_WE_O        = tx_push;
    assign DMI_REQ_VALID_O  = (state_q == S_DMI_REQ);
    assign DMI_RESP_READY_O = (state_q == S_DMI_RESP);
    assign DMI_REQ_OP_O     = op_q;
    assign DMI_REQ_ADDR_O   = addr_q;
    assign DMI_REQ_DATA_O   = wdata_q;
    assign BUSY_O           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_dmi_framer.sv
module tb_uart_dmi_framer;

    localparam int TMO = 16;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        UART_RE_O;
    logic        UART_RX_EMPTY_I = 1'b1;
    logic [7:0]  UART_DREC_I = 8'h00;
    logic        UART_WE_O;
    logic        UART_TX_READY_I = 1'b1;
    logic [7:0]  UART_DSEND_O;
    logic        DMI_REQ_VALID_O;
    logic        DMI_REQ_READY_I = 1'b0;
    logic [1:0]  DMI_REQ_OP_O;
    logic [6:0]  DMI_REQ_ADDR_O;
    logic [31:0] DMI_REQ_DATA_O;
    logic        DMI_RESP_VALID_I = 1'b0;
    logic        DMI_RESP_READY_O;
    logic [1:0]  cfg_op = 2'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        BUSY_O;

    uart_dmi_framer #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(7)) dut (
        .CLK_I            (CLK_I),
        .RST_I            (RST_I),
        .UART_RE_O        (UART_RE_O),
        .UART_RX_EMPTY_I  (UART_RX_EMPTY_I),
        .UART_DREC_I      (UART_DREC_I),
        .UART_WE_O        (UART_WE_O),
        .UART_TX_READY_I  (UART_TX_READY_I),
        .UART_DSEND_O     (UART_DSEND_O),
        .DMI_REQ_VALID_O  (DMI_REQ_VALID_O),
        .DMI_REQ_READY_I  (DMI_REQ_READY_I),
        .DMI_REQ_OP_O     (DMI_REQ_OP_O),
        .DMI_REQ_ADDR_O   (DMI_REQ_ADDR_O),
        .DMI_REQ_DATA_O   (DMI_REQ_DATA_O),
        .DMI_RESP_VALID_I (DMI_RESP_VALID_I),
        .DMI_RESP_READY_O (DMI_RESP_READY_O),
        .DMI_RESP_OP_I    (cfg_op),
        .DMI_RESP_DATA_I  (cfg_data),
        .BUSY_O           (BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } req_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    req_t       req_exp[$];
    logic [7:0] tx_log[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int tx_count = 0;
    int req_count = 0;
    int valid_cycles = 0;
    int ready_delay = 0;
    int req_wait = 0;
    bit pend_resp = 0;
    bit tx_toggle = 0;
    logic [1:0]  last_op = 2'd0;
    logic [6:0]  last_addr = 7'd0;
    logic [31:0] last_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: pop on the edge where the DUT strobes, present the next
    // byte just after the edge.
    always @(posedge CLK_I) begin
        cyc++;
        if (UART_RE_O && rx_q.size() != 0) begin
            void'(rx_q.pop_front());
            last_pop_cyc = cyc;
        end
        #1;
        UART_RX_EMPTY_I = (rx_q.size() == 0);
        UART_DREC_I     = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    always @(posedge CLK_I) begin
        #1;
        UART_TX_READY_I = tx_toggle ? ~UART_TX_READY_I : 1'b1;
    end

    // DMI target: accepts after ready_delay cycles of valid, answers at once.
    always @(posedge CLK_I) begin
        if (RST_I) begin
            pend_resp = 0;
            req_wait  = 0;
        end else begin
            if (DMI_REQ_VALID_O && DMI_REQ_READY_I) begin
                pend_resp = 1;
                req_wait  = 0;
            end else if (DMI_REQ_VALID_O) begin
                req_wait++;
            end
            if (DMI_RESP_READY_O && DMI_RESP_VALID_I) pend_resp = 0;
        end
        #1;
        DMI_REQ_READY_I  = DMI_REQ_VALID_O && (req_wait >= ready_delay);
        DMI_RESP_VALID_I = pend_resp;
    end

    // Compare process: every pushed TX byte and every request-valid cycle is
    // checked against the model queues.
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (UART_WE_O) begin
                tx_count++;
                tx_log.push_back(UART_DSEND_O);
                check("tx_push_on_ready", UART_TX_READY_I, 1);
                if (tx_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got 0x%0h required no byte", UART_DSEND_O);
                end else begin
                    check("tx_byte", UART_DSEND_O, tx_exp.pop_front());
                end
            end
            if (UART_RE_O) check("re_when_nonempty", UART_RX_EMPTY_I, 0);
            if (DMI_REQ_VALID_O) begin
                valid_cycles++;
                if (req_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: got op %0d addr 0x%0h required no request",
                             DMI_REQ_OP_O, DMI_REQ_ADDR_O);
                end else begin
                    check("req_op", DMI_REQ_OP_O, req_exp[0].op);
                    check("req_addr", DMI_REQ_ADDR_O, req_exp[0].addr);
                    if (req_exp[0].op == 2'd2) check("req_data", DMI_REQ_DATA_O, req_exp[0].data);
                    if (DMI_REQ_READY_I) begin
                        void'(req_exp.pop_front());
                        req_count++;
                        last_op   = DMI_REQ_OP_O;
                        last_addr = DMI_REQ_ADDR_O;
                        last_data = DMI_REQ_DATA_O;
                    end
                end
            end
        end
    end

    // Frame-level model: what one frame must produce on DMI and on TX.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [1:0] rop,
                               input logic [31:0] rdata);
        req_t r;
        if (cmd != 8'h01 && cmd != 8'h02) begin
            tx_exp.push_back(8'hFF);
            return;
        end
        r.op   = cmd[1:0];
        r.addr = 7'(addr % 128);
        r.data = wdata;
        req_exp.push_back(r);
        tx_exp.push_back(8'(rop));
        if (cmd == 8'h01 && rop == 2'd0)
            for (int i = 0; i < 4; i++) tx_exp.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge CLK_I);
            n++;
        end while (!(rx_q.size() == 0 && !BUSY_O && tx_exp.size() == 0 &&
                     req_exp.size() == 0) && n < 3000);
        if (n >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_wait: got still busy after %0d cycles required idle", name, n);
        end
        repeat (3) @(negedge CLK_I);
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [1:0] rop,
                             input logic [31:0] rdata);
        cfg_op   = rop;
        cfg_data = rdata;
        tx_log.delete();
        model_frame(cmd, addr, wdata, rop, rdata);
        rx_q.push_back(cmd);
        if (cmd == 8'h01 || cmd == 8'h02) rx_q.push_back(addr);
        if (cmd == 8'h02)
            for (int i = 0; i < 4; i++) rx_q.push_back(8'((wdata >> (8 * i)) & 32'hFF));
        wait_idle(name);
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_busy"}, BUSY_O, 0);
        check({pfx, "_re"}, UART_RE_O, 0);
        check({pfx, "_we"}, UART_WE_O, 0);
        check({pfx, "_dsend"}, UART_DSEND_O, 0);
        check({pfx, "_req_valid"}, DMI_REQ_VALID_O, 0);
        check({pfx, "_resp_ready"}, DMI_RESP_READY_O, 0);
        check({pfx, "_req_op"}, DMI_REQ_OP_O, 0);
        check({pfx, "_req_addr"}, DMI_REQ_ADDR_O, 0);
        check({pfx, "_req_data"}, DMI_REQ_DATA_O, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit_read[5];
        logic [7:0] lit_bp[5];
        int snap_tx, snap_req, n;

        lit_read = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        lit_bp   = '{8'h00, 8'hBE, 8'hBA, 8'hFE, 8'hCA};

        repeat (3) @(posedge CLK_I);
        #1 RST_I = 1'b0;
        @(negedge CLK_I);
        check_quiet("reset");

        // READ ok
        run_frame("read", 8'h01, 8'h05, 32'd0, 2'd0, 32'hDEADBEEF);
        check("read_tx_len", tx_log.size(), 5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++) check("read_tx_lit", tx_log[i], lit_read[i]);
        check("read_last_op", last_op, 1);
        check("read_last_addr", last_addr, 7'h05);

        // WRITE with 5 cycles of request backpressure
        ready_delay  = 5;
        valid_cycles = 0;
        run_frame("write", 8'h02, 8'h10, 32'h12345678, 2'd0, 32'h0);
        ready_delay = 0;
        check("write_valid_cycles", valid_cycles, 6);
        check("write_last_op", last_op, 2);
        check("write_last_addr", last_addr, 7'h10);
        check("write_last_data", last_data, 32'h12345678);
        check("write_tx_len", tx_log.size(), 1);
        if (tx_log.size() > 0) check("write_tx_lit", tx_log[0], 8'h00);

        // Unknown command
        snap_req = req_count;
        run_frame("nak", 8'h7F, 8'h00, 32'd0, 2'd0, 32'd0);
        check("nak_tx_len", tx_log.size(), 1);
        if (tx_log.size() > 0) check("nak_tx_lit", tx_log[0], 8'hFF);
        check("nak_no_req", req_count, snap_req);

        // READ failed, upper address bit ignored
        run_frame("read_fail", 8'h01, 8'hC3, 32'd0, 2'd2, 32'h11223344);
        check("read_fail_tx_len", tx_log.size(), 1);
        if (tx_log.size() > 0) check("read_fail_tx_lit", tx_log[0], 8'h02);
        check("read_fail_addr", last_addr, 7'h43);

        // WRITE busy
        run_frame("write_busy", 8'h02, 8'h7E, 32'hA5A50F0F, 2'd3, 32'd0);
        check("write_busy_tx_len", tx_log.size(), 1);

        // Inter-byte timeout in GET_DATA
        snap_tx  = tx_count;
        snap_req = req_count;
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h01);
        n = 0;
        do begin @(negedge CLK_I); n++; end while (rx_q.size() != 0 && n < 100);
        n = 0;
        while (BUSY_O && n < 200) begin @(negedge CLK_I); n++; end
        check("timeout_idle_cycles", cyc - last_pop_cyc, TMO);
        repeat (3) @(negedge CLK_I);
        check("timeout_no_tx", tx_count, snap_tx);
        check("timeout_no_req", req_count, snap_req);
        run_frame("after_timeout", 8'h01, 8'h33, 32'd0, 2'd0, 32'h0BADF00D);
        check("after_timeout_tx_len", tx_log.size(), 5);

        // TX backpressure toggling every cycle
        tx_toggle = 1;
        run_frame("tx_bp", 8'h01, 8'h44, 32'd0, 2'd0, 32'hCAFEBABE);
        tx_toggle = 0;
        check("tx_bp_len", tx_log.size(), 5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++) check("tx_bp_lit", tx_log[i], lit_bp[i]);

        // Reset in GET_DATA after two data bytes
        snap_tx = tx_count;
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        n = 0;
        do begin @(negedge CLK_I); n++; end while (rx_q.size() != 0 && n < 100);
        @(posedge CLK_I);
        #1 RST_I = 1'b1;
        @(posedge CLK_I);
        #1 RST_I = 1'b0;
        @(negedge CLK_I);
        check_quiet("midrst");
        repeat (20) @(negedge CLK_I);
        check("midrst_no_tx", tx_count, snap_tx);
        run_frame("post_rst_write", 8'h02, 8'h21, 32'hCAFEF00D, 2'd0, 32'd0);
        check("post_rst_data", last_data, 32'hCAFEF00D);
        check("post_rst_addr", last_addr, 7'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_dmi_framer.md
Name: uart_dmi_framer

Overview:
- Command framer that sits directly downstream of the UART interface block, on its host-facing side.
- Pops received bytes from the UART RX FIFO and assembles read/write frames.
- Issues one request per frame on a DMI request/response handshake.
- Serialises the DMI response back into the UART TX FIFO.

Parameters:
TIMEOUT_CYCLES, 1000000, inter-byte timeout in CLK_I cycles while a frame is partially received; must be ≥ 2
ADDR_WIDTH, 7, DMI address width; taken from the low bits of the address byte

Ports:
CLK_I  input  1  system clock
RST_I  input  1  synchronous active-high reset
UART_RE_O  output  1  pop strobe to UART RX FIFO
UART_RX_EMPTY_I  input  1  UART RX FIFO empty
UART_DREC_I  input  8  received byte, valid in the same cycle UART_RE_O=1
UART_WE_O  output  1  push strobe to UART TX FIFO
UART_TX_READY_I  input  1  UART TX FIFO not full
UART_DSEND_O  output  8  byte to transmit, valid when UART_WE_O=1
DMI_REQ_VALID_O  output  1  request valid
DMI_REQ_READY_I  input  1  request accepted
DMI_REQ_OP_O  output  2  1=read, 2=write
DMI_REQ_ADDR_O  output  ADDR_WIDTH  request address
DMI_REQ_DATA_O  output  32  write data
DMI_RESP_VALID_I  input  1  response valid
DMI_RESP_READY_O  output  1  response accepted
DMI_RESP_OP_I  input  2  response status: 0 ok, 2 failed, 3 busy
DMI_RESP_DATA_I  input  32  read data
BUSY_O  output  1  high in every state except IDLE

Behaviour:
- Interface: one clock (CLK_I); reset RST_I is synchronous and active-high.
- Reset values:
  - All strobes/valids 0; DMI_RESP_READY_O 0; BUSY_O 0.
  - DMI_REQ_OP_O/ADDR_O/DATA_O 0; UART_DSEND_O 0.
  - FSM in IDLE; timeout counter 0.
- Reset mid-frame: aborts silently; no DMI request, no response byte.
- RX pop rule:
  - UART_RE_O = ~UART_RX_EMPTY_I in IDLE, GET_ADDR and GET_DATA; 0 in all other states (combinational).
  - A byte is consumed in exactly the cycle UART_RE_O=1, sampling UART_DREC_I.
  - At most one byte per cycle.
- TX push rule:
  - UART_WE_O is combinational = tx_pending & UART_TX_READY_I.
  - UART_DSEND_O holds the current byte while it is pending.
  - Byte advances on the cycle UART_WE_O=1.
  - TX_READY low stalls indefinitely; nothing is dropped.
- Frame format:
  - Byte 0 = command: 0x01 READ, 0x02 WRITE.
  - Byte 1 = address; bits [ADDR_WIDTH-1:0] used, the rest ignored.
  - WRITE only: bytes 2..5 = data, LSB first.
- States:
  - IDLE: on a consumed byte:
    - 0x01 or 0x02: latch op → GET_ADDR.
    - Any other value → SEND_STATUS with status byte 0xFF (unknown-command NAK); no DMI activity.
  - GET_ADDR: consumed byte → latch address.
    - READ → DMI_REQ.
    - WRITE → GET_DATA with byte index 0.
  - GET_DATA: consumed byte → DATA[8*idx +: 8], idx++.
    - After idx 3 → DMI_REQ.
  - DMI_REQ: DMI_REQ_VALID_O=1 with stable op/addr/data until DMI_REQ_READY_I=1, then → DMI_RESP.
    - Entered one cycle after the last byte is consumed.
  - DMI_RESP: DMI_RESP_READY_O=1.
    - On DMI_RESP_VALID_I=1: latch data and status; status byte = {6'b0, DMI_RESP_OP_I} → SEND_STATUS.
  - SEND_STATUS: push status byte.
    - On push: READ with status 0 → SEND_DATA; otherwise → IDLE.
  - SEND_DATA: push the 4 latched data bytes, LSB first, then → IDLE.
- No DMI timeout: DMI_REQ and DMI_RESP wait forever.
- Inter-byte timeout:
  - Counter runs only in GET_ADDR/GET_DATA; clears on every consumed byte and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte consumed: → IDLE; frame discarded, no response.
  - A byte consumed in the expiry cycle takes priority over the timeout.
- Throughput: one frame in flight. Bytes arriving during DMI/SEND states stay in the UART RX FIFO (RE_O=0).

Test Plan:
- READ path: RX bytes 0x01, 0x05; DMI responds op=0, data 0xDEADBEEF → one request (op=1, addr=0x05); TX sequence 0x00, 0xEF, 0xBE, 0xAD, 0xDE.
- WRITE path: RX bytes 0x02, 0x10, 0x78, 0x56, 0x34, 0x12; DMI_REQ_READY held low 5 cycles → REQ fields stable throughout (op=2, addr=0x10, data=0x12345678); response op=0 → TX exactly 0x00.
- Error paths:
  - RX byte 0x7F → TX 0xFF, no DMI_REQ_VALID.
  - READ with response op=2 → TX 0x02 only.
- Timeout with TIMEOUT_CYCLES=16: send 0x02, 0x10, 0x01, then silence → FSM back to IDLE after 16 idle cycles, no TX, no request; then a full READ frame → completes normally.
- Backpressure: during READ response, UART_TX_READY_I toggles 1/0 every cycle → all 5 bytes emitted once, in order, only on ready cycles.
- Reset: RST_I asserted in GET_DATA after 2 data bytes → next cycle all outputs at reset values; new WRITE frame → correct full-data request.
